// File: rtl/cpu_pkg.sv
// Shared CPU definitions: multiplier FSM state encoding and iteration count.
package cpu_pkg;

  typedef enum logic [1:0] {
    MUL_IDLE = 2'd0,
    MUL_CALC = 2'd1,
    MUL_SIGN = 2'd2,
    MUL_DONE = 2'd3
  } mul_state_e;

  localparam int MUL_ITER = 32;

endpackage

// File: rtl/adder.sv
// 32-bit ripple adder shared by the execute stage; overflow_flag reports signed overflow.
module adder #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow_flag
);

  always_comb begin
    {cout, sum}   = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
    overflow_flag = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
  end

endmodule

// File: rtl/mul_iter.sv
// Iterative shift-add 32x32 multiplier (signed/unsigned), one adder pass per cycle.
// Optional macro MUL_ZERO_SKIP_EN: a zero operand finishes in one cycle without busy.
module mul_iter
  import cpu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               start,
  input  logic               mul_signed,
  input  logic [WIDTH-1:0]   operand1,
  input  logic [WIDTH-1:0]   operand2,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  mul_state_e       state, state_nxt;
  logic [WIDTH-1:0] mcand, acc_hi, acc_lo;
  logic [WIDTH-1:0] mag1, mag2, sum;
  logic             cout, neg, take, zero_op;
  logic [CNT_W-1:0] count;
  logic             adder_ovf_unused;

  adder #(.WIDTH(WIDTH)) u_adder (
    .a             (acc_hi),
    .b             (mcand),
    .cin           (1'b0),
    .sum           (sum),
    .cout          (cout),
    .overflow_flag (adder_ovf_unused)
  );

  always_comb begin
    mag1 = (mul_signed && operand1[WIDTH-1]) ? (~operand1 + WIDTH'(1)) : operand1;
    mag2 = (mul_signed && operand2[WIDTH-1]) ? (~operand2 + WIDTH'(1)) : operand2;
    take = start && ((state == MUL_IDLE) || (state == MUL_DONE));
`ifdef MUL_ZERO_SKIP_EN
    zero_op = (operand1 == '0) || (operand2 == '0);
`else
    zero_op = 1'b0;
`endif
  end

  always_comb begin
    state_nxt = state;
    case (state)
      MUL_IDLE: if (start) state_nxt = zero_op ? MUL_DONE : MUL_CALC;
      MUL_CALC: if (count == CNT_W'(MUL_ITER - 1)) state_nxt = MUL_SIGN;
      MUL_SIGN: state_nxt = MUL_DONE;
      MUL_DONE: state_nxt = start ? (zero_op ? MUL_DONE : MUL_CALC) : MUL_IDLE;
      default:  state_nxt = MUL_IDLE;
    endcase
    busy = (state == MUL_CALC) || (state == MUL_SIGN);
    done = (state == MUL_DONE);
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state   <= MUL_IDLE;
      mcand   <= '0;
      acc_hi  <= '0;
      acc_lo  <= '0;
      neg     <= 1'b0;
      count   <= '0;
      product <= '0;
    end else begin
      state <= state_nxt;
      if (take) begin
        mcand  <= mag1;
        acc_hi <= '0;
        acc_lo <= mag2;
        neg    <= mul_signed & (operand1[WIDTH-1] ^ operand2[WIDTH-1]);
        count  <= '0;
        if (zero_op) product <= '0;
      end else if (state == MUL_CALC) begin
        // Shift {cout,sum,acc_lo} right; the carry slot always refills with 0.
        if (acc_lo[0]) begin
          acc_hi <= {cout, sum[WIDTH-1:1]};
          acc_lo <= {sum[0], acc_lo[WIDTH-1:1]};
        end else begin
          acc_hi <= {1'b0, acc_hi[WIDTH-1:1]};
          acc_lo <= {acc_hi[0], acc_lo[WIDTH-1:1]};
        end
        count <= count + CNT_W'(1);
      end else if (state == MUL_SIGN) begin
        product <= neg ? (~{acc_hi, acc_lo} + (2*WIDTH)'(1)) : {acc_hi, acc_lo};
      end
    end
  end

endmodule

// File: doc/mul_iter.md
Name: mul_iter

Overview:
- Iterative shift-add multiplier for the multi-cycle CPU execute stage.
- Computes a 64-bit product of two 32-bit operands, signed or unsigned.
- Reuses the 32-bit adder once per cycle, consuming its result and carry-out.
- Control FSM holds the datapath via start/busy/done handshake; product feeds HI/LO write-back.

Parameters:
- WIDTH, 32, operand width; 32 is the only supported value (matches the adder).
- CNT_W, 6, iteration counter width; must hold the value WIDTH.

Ports:
- clk  input  1  system clock, all state updates on rising edge
- resetn  input  1  synchronous reset, active-low
- start  input  1  request; sampled only in IDLE or DONE
- mul_signed  input  1  1 = two's-complement operands, 0 = unsigned; sampled with start
- operand1  input  32  multiplicand, sampled with start
- operand2  input  32  multiplier, sampled with start
- busy  output  1  high in CALC and SIGN
- done  output  1  one-cycle pulse, high in DONE
- product  output  64  result; valid when done=1, held until the next result is written

Behaviour:
- Reset: one clock and one reset; reset is synchronous and active-low (resetn sampled on the rising edge of clk).
  - resetn=0 forces state=IDLE and clears busy, done, product, the counter and internal registers.
  - Reset mid-operation aborts with no done pulse.
- States: IDLE, CALC, SIGN, DONE.
- IDLE/DONE with start=1 at edge E0:
  - Latch mcand = |operand1| and mplier = |operand2|; absolute values apply only when mul_signed=1.
  - Latch neg = mul_signed & (operand1[31] ^ operand2[31]).
  - Clear acc_hi and carry; load acc_lo = mplier; count = 0; go to CALC.
- DONE with start=0 goes to IDLE. IDLE with start=0 stays in IDLE.
- CALC, each edge:
  - Adder computes acc_hi + mcand with cin=0, giving sum and cout.
  - If acc_lo[0]=1: {carry,acc_hi,acc_lo} = {cout,sum,acc_lo} >> 1.
  - Else: {0,acc_hi,acc_lo} >> 1.
  - count increments. After edge where count becomes 32 (edges E1..E32), go to SIGN.
- SIGN (edge E33): product = neg ? (~{acc_hi,acc_lo} + 1) : {acc_hi,acc_lo}; go to DONE.
- Latency: done=1 in the cycle after E33, i.e. 34 cycles after the start edge. Back-to-back start in DONE is accepted, giving a throughput of 1 result per 34 cycles.
- The adder overflow flag is ignored; cout is the only carry used.
- Magnitude of 0x80000000 is 0x80000000 unsigned (no special case).
- start while busy=1 is ignored; operands are not re-sampled.
- Unsigned results are exact 64-bit products; no truncation, no overflow output.

Optional Feature:
- Macro: MUL_ZERO_SKIP_EN.
- Defined: on start, if operand1==0 or operand2==0, go directly IDLE/DONE to DONE.
  - Product is cleared to 0 at the start edge; done is high the next cycle (latency 1).
  - busy never rises.
- Undefined: zero operands take the full 34-cycle path with a product of 0.

Decomposition:
- Shared package (cpu_pkg): state encoding constants MUL_IDLE=2'd0, MUL_CALC=2'd1, MUL_SIGN=2'd2, MUL_DONE=2'd3; MUL_ITER=32.
- Sub-module: instantiate the existing 32-bit adder for the partial sum (cin tied 0, overflow_flag unconnected).
- The 64-bit negate in SIGN is inline; no second adder instance.

Test Plan:
- Unsigned: 0x00000003 x 0x00000005 -> product=0x000000000000000F, done 34 cycles after start, busy high 33 cycles.
- Unsigned max: 0xFFFFFFFF x 0xFFFFFFFF -> product=0xFFFFFFFE00000001; exercises cout on every iteration.
- Signed: 0xFFFFFFFE (-2) x 0x00000003 -> 0xFFFFFFFFFFFFFFFA; 0x80000000 x 0x80000000 -> 0x4000000000000000.
- Back-to-back and ignored start:
  - start pulsed during CALC with different operands -> ignored, first product correct.
  - start in DONE cycle (7 x 6, unsigned) -> accepted, next product=0x2A.
- Reset mid-op: resetn=0 at cycle 10 of CALC -> next cycle busy=0, done=0, product=0; no done pulse until a new start.
- Zero operand: 0 x 0x12345678.
  - With MUL_ZERO_SKIP_EN: done high the cycle after start, busy never high, product=0.
  - Without: done at 34 cycles, product=0.
